if_prefetch: RTL and testbench

Parametrised instruction-fetch stage. It issues sequential fetch requests to instruction memory over a valid/ready request channel and accepts in-order responses of variable latency. Fetched instructions are buffered in a small prefetch queue with their PCs, and presented to decode through a valid/ready handshake. It sits between the PC/branch logic (redirect source in EX) and the IF/ID boundary, and replaces the single-cycle PC register fetch.

---
 rtl/if_prefetch_pkg.sv | 26 ++
 rtl/if_prefetch_fetch_queue.sv | 60 ++++++
 rtl/if_prefetch.sv | 113 +++++++++++
 tb/tb_if_prefetch.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
//   addr_t / data_t : address and instruction word types
//   enable_t        : single-bit control strobe
//   fetch_entry_t   : one prefetch-queue entry, PC plus instruction
package if_prefetch_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] addr_t;
  typedef logic [WORD_W-1:0] data_t;
  typedef logic              enable_t;

  // addi x0, x0, 0 -- presented to decode whenever nothing is valid.
  localparam data_t NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    addr_t pc;
    data_t instr;
  } fetch_entry_t;

  // Sequential word address; wraps modulo 2^WORD_W.
  function automatic addr_t next_word(input addr_t a);
    return a + addr_t'(4);
  endfunction

endpackage

// File: rtl/if_prefetch_fetch_queue.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of fetch entries.
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_entry at the tail
//   pop         : drop the head entry
//   flush       : empty the queue; wins over push and pop
//   push_entry  : entry to write
//   head        : current head entry (undefined contents when count == 0)
//   count       : number of valid entries, 0..DEPTH
module fetch_queue
  import if_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               push_entry,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // DEPTH is a power of two, so this mask is the natural pointer wrap.
  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr + AW'(1)) & PTR_MASK;
      if (pop)  rd_ptr <= (rd_ptr + AW'(1)) & PTR_MASK;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count qualifies every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch stage.
// Issues sequential fetch requests over a valid/ready channel, tracks
// in-order variable-latency responses, buffers them with their PCs and
// hands them to decode over a valid/ready handshake. A redirect flushes
// the buffer, restarts fetch at the target and drops responses to any
// requests still in flight.
//   clk, rst             : clock, asynchronous active-high reset
//   redirect_i/_addr_i   : flush and restart fetch at the given address
//   imem_req_*           : fetch request channel (valid/ready/addr)
//   imem_resp_*          : in-order response channel (valid/data)
//   valid_o / ready_i    : decode handshake
//   instruction_o, pc_o, pc_next_o : head entry (NOP / 0 / 0 when invalid)
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [XLEN-1:0] imem_resp_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  addr_t         fetch_pc;
  addr_t         resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] cnt;
  logic [CW-1:0] live;
  logic [CW:0]   credit_used;
  logic          accept;
  logic          keep;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Requests still owed a slot: queued entries plus live in-flight fetches.
  assign live        = outstanding - discard;
  assign credit_used = {1'b0, cnt} + {1'b0, live};

  assign imem_req_valid_o = !rst && !redirect_i
                            && (credit_used < DEPTH_W)
                            && (outstanding < DEPTH_C);
  assign imem_req_addr_o  = fetch_pc;
  assign accept           = imem_req_valid_o && imem_req_ready_i;

  // A response landing in a redirect cycle belongs to the old stream.
  assign keep = imem_resp_valid_i && !redirect_i && (discard == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (redirect_i) begin
        fetch_pc <= redirect_addr_i;
        resp_pc  <= redirect_addr_i;
      end else begin
        if (accept) fetch_pc <= next_word(fetch_pc);
        if (keep)   resp_pc  <= next_word(resp_pc);
      end

      outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid_i);

      // No request is accepted in a redirect cycle, so everything still
      // outstanding after this edge belongs to the abandoned stream.
      if (redirect_i)
        discard <= outstanding - CW'(imem_resp_valid_i);
      else if (imem_resp_valid_i && (discard != '0))
        discard <= discard - CW'(1);
    end
  end

  assign push_entry = '{pc: resp_pc, instr: imem_resp_data_i};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (keep),
    .pop        (pop),
    .flush      (redirect_i),
    .push_entry (push_entry),
    .head       (head),
    .count      (cnt)
  );

  assign valid_o       = (cnt != '0) && !redirect_i;
  assign pop           = valid_o && ready_i;
  assign instruction_o = valid_o ? head.instr : NOP_INSTR;
  assign pc_o          = valid_o ? head.pc : '0;
  assign pc_next_o     = valid_o ? next_word(head.pc) : '0;

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;
  import if_prefetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        valid;
  logic        ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_next;

  // Second instance, no responses ever, used for reset-PC wrap checks.
  logic        w_req_valid;
  logic        w_req_ready = 1'b0;
  logic [31:0] w_req_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc_next;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          rand_ready = 1'b0;
  exp_t        sb[$];
  pend_t       pend[$];
  logic [31:0] exp_req_pc = 32'h0;

  always #5 clk = ~clk;

  if_prefetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect), .redirect_addr_i(redirect_addr),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready),
    .imem_req_addr_o(req_addr),
    .imem_resp_valid_i(resp_valid), .imem_resp_data_i(resp_data),
    .valid_o(valid), .ready_i(ready),
    .instruction_o(instr), .pc_o(pc), .pc_next_o(pc_next)
  );

  if_prefetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
    .clk(clk), .rst(rst),
    .redirect_i(1'b0), .redirect_addr_i(32'h0),
    .imem_req_valid_o(w_req_valid), .imem_req_ready_i(w_req_ready),
    .imem_req_addr_o(w_req_addr),
    .imem_resp_valid_i(1'b0), .imem_resp_data_i(32'h0),
    .valid_o(w_valid), .ready_i(1'b0),
    .instruction_o(w_instr), .pc_o(w_pc), .pc_next_o(w_pc_next)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Memory model and scoreboard: expected entries are queued when a request
  // is accepted and compared when decode pops.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    cyc++;
    #1;
    resp_valid = 1'b0;
    resp_data  = '0;
    if (rst) begin
      pend.delete();
      sb.delete();
      exp_req_pc = 32'h0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end
    req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (!rst) begin
      if (redirect) begin
        sb.delete();
        exp_req_pc = redirect_addr;
      end else begin
        if (req_valid && req_ready) begin
          tests++;
          if (req_addr !== exp_req_pc) begin
            fails++;
            $display("FAIL req_addr: got %h expected %h", req_addr, exp_req_pc);
          end
          sb.push_back('{pc: exp_req_pc, instr: instr_of(exp_req_pc)});
          pend.push_back('{addr: req_addr, due: cyc + lat});
          exp_req_pc = exp_req_pc + 32'd4;
        end
        if (valid && ready) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pop: got pc %h expected no valid entry", pc);
          end else begin
            e = sb.pop_front();
            if (pc !== e.pc || instr !== e.instr || pc_next !== 32'(e.pc + 32'd4)) begin
              fails++;
              $display("FAIL pop_entry: got pc %h instr %h next %h expected pc %h instr %h next %h",
                       pc, instr, pc_next, e.pc, e.instr, 32'(e.pc + 32'd4));
            end
          end
        end
      end
    end
  end

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int n = 0;
    while (!valid && n < 20) begin
      @(negedge clk); #3;
      n++;
    end
    tests++;
    if (!valid || pc !== exp_pc || instr !== instr_of(exp_pc)) begin
      fails++;
      $display("FAIL %s: got valid %b pc %h instr %h expected pc %h instr %h",
               name, valid, pc, instr, exp_pc, instr_of(exp_pc));
    end
  endtask

  task automatic test_reset();
    int lows = 0;
    rst = 1'b1; ready = 1'b1; redirect = 1'b0; lat = 1;
    repeat (3) @(negedge clk);
    #3;
    tests++;
    if (req_valid !== 1'b0 || req_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_req: got valid %b addr %h expected 0 00000000", req_valid, req_addr);
    end
    tests++;
    if (valid !== 1'b0 || instr !== NOP_INSTR || pc !== 32'h0 || pc_next !== 32'h0) begin
      fails++;
      $display("FAIL reset_out: got valid %b instr %h pc %h next %h expected 0 %h 0 0",
               valid, instr, pc, pc_next, NOP_INSTR);
    end
    tests++;
    if (w_req_addr !== 32'hFFFF_FFF8 || w_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_pc_param: got addr %h valid %b expected fffffff8 0", w_req_addr, w_req_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #3;
    tests++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL first_req: got req %b addr %h valid %b expected 1 00000000 0", req_valid, req_addr, valid);
    end
    @(negedge clk); #3;
    tests++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL fill_cycle1: got valid %b expected 0", valid);
    end
    @(negedge clk); #3;
    tests++;
    if (valid !== 1'b1 || pc !== 32'h0 || pc_next !== 32'h4) begin
      fails++;
      $display("FAIL fill_cycle2: got valid %b pc %h next %h expected 1 00000000 00000004", valid, pc, pc_next);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #3;
      if (!valid) lows++;
    end
    tests++;
    if (lows != 0) begin
      fails++;
      $display("FAIL throughput: got %0d bubbles expected 0", lows);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    rst = 1'b1; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    tests++;
    if (req_valid !== 1'b0 || sb.size() != 4 || pend.size() != 0) begin
      fails++;
      $display("FAIL stall_fill: got req %b buffered %0d inflight %0d expected 0 4 0",
               req_valid, sb.size(), pend.size());
    end
    @(negedge clk);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      tests++;
      if (valid !== 1'b1 || pc !== 32'(4 * i)) begin
        fails++;
        $display("FAIL stall_release: got valid %b pc %h expected 1 %h", valid, pc, 32'(4 * i));
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_redirect_inflight();
    lat = 3;
    repeat (8) @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 32'h100;
    #3;
    tests++;
    if (valid !== 1'b0 || req_valid !== 1'b0) begin
      fails++;
      $display("FAIL redirect_cycle: got valid %b req %b expected 0 0", valid, req_valid);
    end
    @(negedge clk);
    redirect = 1'b0;
    #3;
    tests++;
    if (req_addr !== 32'h100) begin
      fails++;
      $display("FAIL redirect_addr: got %h expected 00000100", req_addr);
    end
    wait_valid("redirect_target", 32'h100);
    repeat (6) @(negedge clk);
    lat = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_redirect_coincident();
    @(negedge clk); #3;
    tests++;
    if (valid !== 1'b1) begin
      fails++;
      $display("FAIL coinc_pre: got valid %b expected 1", valid);
    end
    @(negedge clk);
    redirect = 1'b1;
    redirect_addr = 32'h200;
    #3;
    tests++;
    if (resp_valid !== 1'b1 || valid !== 1'b0) begin
      fails++;
      $display("FAIL coinc_cycle: got resp %b valid %b expected 1 0", resp_valid, valid);
    end
    @(negedge clk);
    redirect = 1'b0;
    #3;
    wait_valid("coinc_target", 32'h200);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rand_ready = 1'b0;
    ready = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if (sb.size() > 4) begin
      fails++;
      $display("FAIL bp_drain: got %0d pending expected at most 4", sb.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w = 32'hFFFF_FFF8;
    int k = 0;
    int n = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk);
      w_req_ready = 1'($urandom_range(0, 1));
      #3;
      n++;
      tests++;
      if (w_req_valid !== 1'b1 || w_req_addr !== exp_w) begin
        fails++;
        $display("FAIL wrap_addr: got valid %b addr %h expected 1 %h", w_req_valid, w_req_addr, exp_w);
      end
      if (w_req_ready) begin
        exp_w = exp_w + 32'd4;
        k++;
      end
    end
    @(negedge clk);
    w_req_ready = 1'b0;
    #3;
    tests++;
    if (k != 4 || w_req_valid !== 1'b0 || w_req_addr !== 32'h8) begin
      fails++;
      $display("FAIL wrap_cap: got accepts %0d valid %b addr %h expected 4 0 00000008", k, w_req_valid, w_req_addr);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); #3;
    tests++;
    if (valid !== 1'b1) begin
      fails++;
      $display("FAIL areset_pre: got valid %b expected 1", valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    pend.delete();
    exp_req_pc = 32'h0;
    resp_valid = 1'b0;
    #1;
    tests++;
    if (valid !== 1'b0 || req_valid !== 1'b0 || req_addr !== 32'h0 ||
        instr !== NOP_INSTR || pc !== 32'h0 || pc_next !== 32'h0) begin
      fails++;
      $display("FAIL areset_now: got valid %b req %b addr %h instr %h pc %h next %h expected reset values",
               valid, req_valid, req_addr, instr, pc, pc_next);
    end
    #1;
    rst = 1'b0;
    @(negedge clk); #3;
    tests++;
    if (req_valid !== 1'b1 || req_addr !== 32'h0) begin
      fails++;
      $display("FAIL areset_restart: got req %b addr %h expected 1 00000000", req_valid, req_addr);
    end
    wait_valid("areset_first", 32'h0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_stall();
    test_redirect_inflight();
    test_redirect_coincident();
    test_backpressure();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
